// File: rtl/rv32_ex_pkg.sv
// rtl/rv32_ex_pkg.sv - shared types and constants for the RV32 execute stage with accelerator port
package rv32_ex_pkg;

    typedef enum logic [2:0] {
        BR_NEVER  = 3'd0,
        BR_EQ     = 3'd1,
        BR_NE     = 3'd2,
        BR_LT     = 3'd3,
        BR_GE     = 3'd4,
        BR_LTU    = 3'd5,
        BR_GEU    = 3'd6,
        BR_ALWAYS = 3'd7
    } rv32_branch_op_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND
    } rv32_alu_op_t;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} rv32_src1_t;
    typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} rv32_src2_t;

    typedef enum logic [2:0] {
        ACC_IDLE, ACC_REQ, ACC_WAIT, ACC_DONE, ACC_DRAIN
    } rv32_acc_state_t;

    typedef struct packed {
        logic            exception;
        logic [3:0]      cause;
        logic            mem_read;
        logic            mem_write;
        logic            csr;
        rv32_branch_op_t branch_op;
        logic            ecall;
        logic            ebreak;
        logic            mret;
        logic [4:0]      rd;
        logic            rd_write;
    } rv32_ex_ctrl_t;

    typedef struct packed {
        rv32_alu_op_t op;
        logic         sub_sra;
        rv32_src1_t   src1;
        rv32_src2_t   src2;
        logic         branch_pc_src;
        logic         predicted_taken;
    } rv32_alu_ctrl_t;

    localparam rv32_ex_ctrl_t RV32_EX_CTRL_NOP = '{
        exception: 1'b0, cause: 4'd0, mem_read: 1'b0, mem_write: 1'b0, csr: 1'b0,
        branch_op: BR_NEVER, ecall: 1'b0, ebreak: 1'b0, mret: 1'b0, rd: 5'd0, rd_write: 1'b0
    };

    localparam logic [3:0] RV32_ACC_TIMEOUT_CAUSE = 4'd14;

    // Memory stage wins over writeback; x0 always reads the register file value.
    function automatic logic [31:0] rv32_forward(
        input logic        enable,
        input logic [4:0]  rs,
        input logic [31:0] rf_value,
        input logic        mem_hit,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_value,
        input logic        wb_hit,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_value
    );
        logic [31:0] value;
        value = rf_value;
        if (enable && rs != 5'd0) begin
            if (mem_hit && mem_rd == rs) begin
                value = mem_value;
            end else if (wb_hit && wb_rd == rs) begin
                value = wb_value;
            end
        end
        return value;
    endfunction

    function automatic rv32_ex_ctrl_t rv32_flush_ctrl(input rv32_ex_ctrl_t c);
        rv32_ex_ctrl_t f;
        f           = c;
        f.exception = 1'b0;
        f.mem_read  = 1'b0;
        f.mem_write = 1'b0;
        f.csr       = 1'b0;
        f.branch_op = BR_NEVER;
        f.ecall     = 1'b0;
        f.ebreak    = 1'b0;
        f.mret      = 1'b0;
        f.rd_write  = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/rv32_execute_acc_port.sv
// rtl/rv32_execute_acc_port.sv - accelerator request/response FSM with response watchdog
module rv32_acc_port
    import rv32_ex_pkg::*;
#(
    parameter int FUNC_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              start,
    input  logic [31:0]       a_in,
    input  logic [31:0]       b_in,
    input  logic [FUNC_W-1:0] func_in,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [31:0]       a_out,
    output logic [31:0]       b_out,
    output logic [FUNC_W-1:0] func_out,
    input  logic              resp_valid,
    input  logic [31:0]       resp_data,
    output rv32_acc_state_t   state,
    output logic [31:0]       result,
    output logic              timed_out
);

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    rv32_acc_state_t state_next;
    logic [7:0]      wd_count;
    logic            wd_fire;

    // Fires at the end of the TIMEOUT-th WAIT cycle, i.e. as the count reaches TIMEOUT.
    assign wd_fire   = (TIMEOUT != 0) && (wd_count == WD_LAST);
    assign req_valid = (state == ACC_REQ);

    always_comb begin
        state_next = state;
        case (state)
            ACC_IDLE: begin
                if (start) state_next = ACC_REQ;
            end
            ACC_REQ: begin
                if (flush) state_next = req_ready ? ACC_DRAIN : ACC_IDLE;
                else if (req_ready) state_next = ACC_WAIT;
            end
            ACC_WAIT: begin
                if (resp_valid || wd_fire) state_next = flush ? ACC_IDLE : ACC_DONE;
                else if (flush) state_next = ACC_DRAIN;
            end
            ACC_DRAIN: begin
                if (resp_valid || wd_fire) state_next = ACC_IDLE;
            end
            ACC_DONE: begin
                if (flush || !stall) state_next = ACC_IDLE;
            end
            default: state_next = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACC_IDLE;
            wd_count  <= 8'd0;
            a_out     <= 32'd0;
            b_out     <= 32'd0;
            func_out  <= '0;
            result    <= 32'd0;
            timed_out <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                a_out     <= a_in;
                b_out     <= b_in;
                func_out  <= func_in;
                timed_out <= 1'b0;
            end
            if (state == ACC_REQ) begin
                wd_count <= 8'd0;
            end else if ((state == ACC_WAIT || state == ACC_DRAIN) && wd_count != 8'hFF) begin
                wd_count <= wd_count + 8'd1;
            end
            if (state == ACC_WAIT && state_next == ACC_DONE) begin
                result    <= resp_valid ? resp_data : 32'd0;
                timed_out <= !resp_valid;
            end
        end
    end

endmodule

// File: rtl/rv32_execute_acc.sv
// rtl/rv32_execute_acc.sv - RV32 execute stage: single-cycle ALU/branch target plus accelerator port
module rv32_execute_acc
    import rv32_ex_pkg::*;
#(
    parameter int         BYPASSING         = 0,
    parameter int         ACC_FUNC_W        = 9,
    parameter int         ACC_TIMEOUT       = 255,
    parameter logic [3:0] ACC_TIMEOUT_CAUSE = RV32_ACC_TIMEOUT_CAUSE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  mem_flush_in,
    input  logic                  writeback_flush_in,
    input  logic                  valid_in,
    input  rv32_ex_ctrl_t         ctrl_in,
    input  rv32_alu_ctrl_t        alu_ctrl_in,
    input  logic                  acc_op_in,
    input  logic [ACC_FUNC_W-1:0] acc_func_in,
    input  logic                  acc_use_imm_in,
    input  logic [4:0]            rs1_in,
    input  logic [4:0]            rs2_in,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           rs1_value_in,
    input  logic [31:0]           rs2_value_in,
    input  logic [31:0]           imm_value_in,
    input  logic [4:0]            writeback_rd_in,
    input  logic                  writeback_rd_write_in,
    input  logic [31:0]           writeback_rd_value_in,
    output logic                  acc_req_valid_out,
    input  logic                  acc_req_ready_in,
    output logic [31:0]           acc_a_out,
    output logic [31:0]           acc_b_out,
    output logic [ACC_FUNC_W-1:0] acc_func_out,
    input  logic                  acc_resp_valid_in,
    input  logic [31:0]           acc_resp_data_in,
    output logic                  busy_out,
    output logic                  valid_out,
    output rv32_ex_ctrl_t         ctrl_out,
    output logic                  branch_misaligned_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           result_out,
    output logic [31:0]           rs1_value_out,
    output logic [31:0]           rs2_value_out,
    output logic [31:0]           imm_value_out,
    output logic [31:0]           branch_pc_out
);

    logic [31:0]     rs1_fwd, rs2_fwd, op_a, op_b, alu_result;
    logic [31:0]     branch_base, branch_target, acc_a_in;
    logic            mem_hit, wb_hit, acc_start, acc_timed_out;
    logic [31:0]     acc_result;
    rv32_acc_state_t acc_state;

    rv32_ex_ctrl_t   hold_ctrl, ctrl_next;
    logic [31:0]     hold_pc, hold_rs1, hold_rs2, hold_imm;
    logic            valid_next, misaligned_next;
    logic [31:0]     pc_next, result_next, rs1_next, rs2_next, imm_next, branch_pc_next;

    assign mem_hit = ctrl_out.rd_write && !mem_flush_in;
    assign wb_hit  = writeback_rd_write_in && !writeback_flush_in;
    assign rs1_fwd = rv32_forward(BYPASSING != 0, rs1_in, rs1_value_in, mem_hit, ctrl_out.rd,
                                  result_out, wb_hit, writeback_rd_in, writeback_rd_value_in);
    assign rs2_fwd = rv32_forward(BYPASSING != 0, rs2_in, rs2_value_in, mem_hit, ctrl_out.rd,
                                  result_out, wb_hit, writeback_rd_in, writeback_rd_value_in);

    always_comb begin
        op_a = 32'd0;
        op_b = 32'd0;
        case (alu_ctrl_in.src1)
            SRC1_RS1: op_a = rs1_fwd;
            SRC1_PC:  op_a = pc_in;
            default:  op_a = 32'd0;
        endcase
        case (alu_ctrl_in.src2)
            SRC2_RS2:  op_b = rs2_fwd;
            SRC2_IMM:  op_b = imm_value_in;
            SRC2_FOUR: op_b = 32'd4;
            default:   op_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl_in.op)
            ALU_ADD:  alu_result = alu_ctrl_in.sub_sra ? op_a - op_b : op_a + op_b;
            ALU_SLL:  alu_result = op_a << op_b[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {31'd0, op_a < op_b};
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SRL:  alu_result = alu_ctrl_in.sub_sra ? 32'($signed(op_a) >>> op_b[4:0])
                                                       : op_a >> op_b[4:0];
            ALU_OR:   alu_result = op_a | op_b;
            ALU_AND:  alu_result = op_a & op_b;
            default:  alu_result = 32'd0;
        endcase
    end

    // Register-relative targets (jalr) drop bit 0; the redirect PC is the path not predicted.
    assign branch_base   = alu_ctrl_in.branch_pc_src ? rs1_fwd : pc_in;
    assign branch_target = (branch_base + imm_value_in) & ~{31'd0, alu_ctrl_in.branch_pc_src};

    assign acc_start = (acc_state == ACC_IDLE) && valid_in && acc_op_in && !flush_in && !stall_in;
    assign busy_out  = (acc_state == ACC_REQ) || (acc_state == ACC_WAIT) || (acc_state == ACC_DRAIN)
                     || ((acc_state == ACC_IDLE) && valid_in && acc_op_in);
    assign acc_a_in  = acc_use_imm_in ? imm_value_in : rs1_fwd;

    rv32_acc_port #(
        .FUNC_W  (ACC_FUNC_W),
        .TIMEOUT (ACC_TIMEOUT)
    ) u_acc_port (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall_in),
        .flush      (flush_in),
        .start      (acc_start),
        .a_in       (acc_a_in),
        .b_in       (rs2_fwd),
        .func_in    (acc_func_in),
        .req_valid  (acc_req_valid_out),
        .req_ready  (acc_req_ready_in),
        .a_out      (acc_a_out),
        .b_out      (acc_b_out),
        .func_out   (acc_func_out),
        .resp_valid (acc_resp_valid_in),
        .resp_data  (acc_resp_data_in),
        .state      (acc_state),
        .result     (acc_result),
        .timed_out  (acc_timed_out)
    );

    always_comb begin
        valid_next      = 1'b0;
        ctrl_next       = RV32_EX_CTRL_NOP;
        pc_next         = pc_in;
        result_next     = alu_result;
        rs1_next        = rs1_fwd;
        rs2_next        = rs2_fwd;
        imm_next        = imm_value_in;
        branch_pc_next  = alu_ctrl_in.predicted_taken ? pc_in + 32'd4 : branch_target;
        misaligned_next = 1'b0;
        if (acc_state == ACC_DONE) begin
            valid_next     = 1'b1;
            ctrl_next      = hold_ctrl;
            pc_next        = hold_pc;
            result_next    = acc_result;
            rs1_next       = hold_rs1;
            rs2_next       = hold_rs2;
            imm_next       = hold_imm;
            branch_pc_next = 32'd0;
            if (acc_timed_out) begin
                ctrl_next.exception = 1'b1;
                ctrl_next.cause     = ACC_TIMEOUT_CAUSE;
                ctrl_next.rd_write  = 1'b0;
            end
        end else if (acc_state == ACC_IDLE && valid_in && !acc_op_in) begin
            valid_next      = 1'b1;
            ctrl_next       = ctrl_in;
            misaligned_next = (ctrl_in.branch_op != BR_NEVER) && branch_target[1];
        end
        if (flush_in) begin
            valid_next      = 1'b0;
            ctrl_next       = rv32_flush_ctrl(ctrl_next);
            misaligned_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_ctrl             <= RV32_EX_CTRL_NOP;
            hold_pc               <= 32'd0;
            hold_rs1              <= 32'd0;
            hold_rs2              <= 32'd0;
            hold_imm              <= 32'd0;
            valid_out             <= 1'b0;
            ctrl_out              <= RV32_EX_CTRL_NOP;
            branch_misaligned_out <= 1'b0;
            pc_out                <= 32'd0;
            result_out            <= 32'd0;
            rs1_value_out         <= 32'd0;
            rs2_value_out         <= 32'd0;
            imm_value_out         <= 32'd0;
            branch_pc_out         <= 32'd0;
        end else begin
            if (acc_start) begin
                hold_ctrl <= ctrl_in;
                hold_pc   <= pc_in;
                hold_rs1  <= rs1_fwd;
                hold_rs2  <= rs2_fwd;
                hold_imm  <= imm_value_in;
            end
            if (flush_in || !stall_in) begin
                valid_out             <= valid_next;
                ctrl_out              <= ctrl_next;
                branch_misaligned_out <= misaligned_next;
                pc_out                <= pc_next;
                result_out            <= result_next;
                rs1_value_out         <= rs1_next;
                rs2_value_out         <= rs2_next;
                imm_value_out         <= imm_next;
                branch_pc_out         <= branch_pc_next;
            end
        end
    end

endmodule
